// File: rtl/approx_add_pkg.sv
// Shared arithmetic for the lower-part-OR approximate adder: the approximate and exact sum functions.
package approx_add_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int SUM_W     = DEF_WIDTH + 1;
  localparam int MAX_W     = 64;

  typedef logic [MAX_W-1:0] opnd_t;
  typedef logic [MAX_W:0]   wsum_t;

  // Low k bits are a|b; carry into bit k is a[k-1]&b[k-1]; bits k..width-1 ripple exactly.
  function automatic wsum_t approx_sum(input opnd_t a, input opnd_t b, input int width,
                                       input int k);
    wsum_t r;
    logic  c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < k) begin
        r[i] = a[i] | b[i];
        c    = a[i] & b[i];
      end else if (i < width) begin
        r[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end else if (i == width) begin
        r[i] = c;
      end
    end
    if (width == MAX_W) r[MAX_W] = c;
    return r;
  endfunction

  function automatic wsum_t exact_sum(input opnd_t a, input opnd_t b, input int width);
    return approx_sum(a, b, width, 0);
  endfunction

endpackage

// File: rtl/approx_add_stage.sv
// One pipeline register slice: a valid bit (synchronously reset) plus an unreset payload.
module approx_add_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  assign valid_d = en_i ? valid_i : valid_q;
  assign data_d  = en_i ? data_i  : data_q;

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined lower-part-OR approximate adder with valid/ready streaming on both sides.
// Optional error statistics are built when APPROX_ADD_ERRSTAT_EN is defined.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int APPROX_LSB = 2,
  parameter int STAGES     = 2,
  parameter int ERR_SUM_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef APPROX_ADD_ERRSTAT_EN
  input  logic                  stat_clr,
  output logic [31:0]           err_cnt,
  output logic [WIDTH:0]        err_max,
  output logic [ERR_SUM_W-1:0]  err_sum,
`endif
  output logic [WIDTH:0]        out_sum
);

  localparam int RES_W = WIDTH + 1;
`ifdef APPROX_ADD_ERRSTAT_EN
  localparam int PW = 2 * RES_W;
`else
  localparam int PW = RES_W;
`endif

  // Handshake: a beat moves when valid & ready on that side; the whole pipe
  // advances together whenever the output slot is empty or being drained.
  logic                         adv;
  logic                         op_vld;
  logic [2*WIDTH-1:0]           op_q;
  logic [STAGES-1:0]            vld;
  logic [STAGES-1:0][PW-1:0]    res;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv | rst;

  approx_add_stage #(.W(2 * WIDTH)) u_ops (
    .clk     (clk),
    .rst     (rst),
    .en_i    (adv),
    .valid_i (in_valid),
    .data_i  ({in_a, in_b}),
    .valid_o (op_vld),
    .data_o  (op_q)
  );

  assign vld[0] = op_vld;
  assign res[0][RES_W-1:0] = RES_W'(approx_sum(opnd_t'(op_q[2*WIDTH-1:WIDTH]),
                                               opnd_t'(op_q[WIDTH-1:0]), WIDTH, APPROX_LSB));
`ifdef APPROX_ADD_ERRSTAT_EN
  assign res[0][PW-1:RES_W] = RES_W'(exact_sum(opnd_t'(op_q[2*WIDTH-1:WIDTH]),
                                               opnd_t'(op_q[WIDTH-1:0]), WIDTH));
`endif

  for (genvar s = 1; s < STAGES; s++) begin : g_slice
    approx_add_stage #(.W(PW)) u_slice (
      .clk     (clk),
      .rst     (rst),
      .en_i    (adv),
      .valid_i (vld[s-1]),
      .data_i  (res[s-1]),
      .valid_o (vld[s]),
      .data_o  (res[s])
    );
  end

  assign out_valid = vld[STAGES-1];
  assign out_sum   = res[STAGES-1][RES_W-1:0];

`ifdef APPROX_ADD_ERRSTAT_EN
  localparam int SW2 = ((ERR_SUM_W > RES_W) ? ERR_SUM_W : RES_W) + 1;

  logic [RES_W-1:0]     apx, exa, err;
  logic [31:0]          cnt_q, cnt_d;
  logic [RES_W-1:0]     max_q, max_d;
  logic [ERR_SUM_W-1:0] sum_q, sum_d;
  logic [SW2-1:0]       sum_wide;

  assign apx = res[STAGES-1][RES_W-1:0];
  assign exa = res[STAGES-1][PW-1:RES_W];
  assign err = (apx >= exa) ? (apx - exa) : (exa - apx);

  // A clear wins over the error of a transfer in the same cycle.
  always_comb begin
    cnt_d    = cnt_q;
    max_d    = max_q;
    sum_d    = sum_q;
    sum_wide = SW2'(sum_q) + SW2'(err);
    if (stat_clr) begin
      cnt_d = '0;
      max_d = '0;
      sum_d = '0;
    end else if (out_valid && out_ready && (err != '0)) begin
      if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
      if (err > max_q) max_d = err;
      sum_d = (sum_wide > SW2'({ERR_SUM_W{1'b1}})) ? '1 : ERR_SUM_W'(sum_wide);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
      sum_q <= sum_d;
    end
  end

  assign err_cnt = cnt_q;
  assign err_max = max_q;
  assign err_sum = sum_q;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe: an approximate instance (K=3, 2 stages) and an exact one (K=0, 3 stages).
module tb_approx_add_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a, in_b;
  logic       out_ready;
  logic       stat_clr;

  logic       ir3, ov3, ir0, ov0;
  logic [8:0] s3, s0;
`ifdef APPROX_ADD_ERRSTAT_EN
  logic [31:0] ec3, ec0;
  logic [8:0]  em3, em0;
  logic [4:0]  es3;
  logic [31:0] es0;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic       hold[2]     = '{1'b0, 1'b0};
  logic [8:0] hold_sum[2] = '{9'd0, 9'd0};
  int         out_cnt[2]  = '{0, 0};

  approx_add_pipe #(.WIDTH(8), .APPROX_LSB(3), .STAGES(2), .ERR_SUM_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (ir3),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (ov3),
    .out_ready (out_ready),
`ifdef APPROX_ADD_ERRSTAT_EN
    .stat_clr  (stat_clr),
    .err_cnt   (ec3),
    .err_max   (em3),
    .err_sum   (es3),
`endif
    .out_sum   (s3)
  );

  approx_add_pipe #(.WIDTH(8), .APPROX_LSB(0), .STAGES(3), .ERR_SUM_W(32)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (ir0),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (ov0),
    .out_ready (out_ready),
`ifdef APPROX_ADD_ERRSTAT_EN
    .stat_clr  (stat_clr),
    .err_cnt   (ec0),
    .err_max   (em0),
    .err_sum   (es0),
`endif
    .out_sum   (s0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: plain arithmetic over the approximation rule.
  function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b, input int k);
    int unsigned p, lo, c, hi;
    p  = 1 << k;
    lo = int'(a | b) % p;
    c  = (k > 0) ? ((int'(a) / (p / 2)) % 2) * ((int'(b) / (p / 2)) % 2) : 0;
    hi = int'(a) / p + int'(b) / p + c;
    return 9'(hi * p + lo);
  endfunction

  // scoreboard step, one call per instance per cycle
  task automatic sb_step(input int id, input logic r, input logic iv, input logic ir,
                         input logic [7:0] a, input logic [7:0] b, input logic ov,
                         input logic orr, input logic [8:0] s);
    logic [8:0] e;
    int         qs;
    if (r) begin
      if (id == 0) exp_q0.delete();
      else         exp_q1.delete();
      hold[id] = 1'b0;
      return;
    end
    if (hold[id]) begin
      chk(id == 0 ? "stall_valid_k3" : "stall_valid_k0", 32'(ov), 32'd1);
      chk(id == 0 ? "stall_sum_k3" : "stall_sum_k0", 32'(s), 32'(hold_sum[id]));
    end
    if (ov && orr) begin
      out_cnt[id]++;
      qs = (id == 0) ? exp_q0.size() : exp_q1.size();
      if (qs == 0) begin
        chk(id == 0 ? "spurious_out_k3" : "spurious_out_k0", 32'(ov), 32'd0);
      end else begin
        if (id == 0) e = exp_q0.pop_front();
        else         e = exp_q1.pop_front();
        chk(id == 0 ? "sb_sum_k3" : "sb_sum_k0", 32'(s), 32'(e));
      end
    end
    if (iv && ir) begin
      if (id == 0) exp_q0.push_back(model_sum(a, b, 3));
      else         exp_q1.push_back(model_sum(a, b, 0));
    end
    hold[id]     = ov & ~orr;
    hold_sum[id] = s;
  endtask

  always @(negedge clk) begin
    sb_step(0, rst, in_valid, ir3, in_a, in_b, ov3, out_ready, s3);
    sb_step(1, rst, in_valid, ir0, in_a, in_b, ov0, out_ready, s0);
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp3;
    logic [8:0] exp0;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    int         c3, c0;
    logic [8:0] h3, h0;

    tbl[0] = '{8'h07, 8'h01, 9'h007, 9'h008};
    tbl[1] = '{8'hFF, 8'hFF, 9'h1FF, 9'h1FE};
    tbl[2] = '{8'h00, 8'h00, 9'h000, 9'h000};
    tbl[3] = '{8'h0C, 8'h04, 9'h014, 9'h010};
    tbl[4] = '{8'h80, 8'h80, 9'h100, 9'h100};
    tbl[5] = '{8'hA5, 8'h5A, 9'h0FF, 9'h0FF};
    tbl[6] = '{8'h03, 8'h05, 9'h007, 9'h008};
    tbl[7] = '{8'h7C, 8'h04, 9'h084, 9'h080};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; stat_clr = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready_k3", 32'(ir3), 32'd1);
    chk("rst_in_ready_k0", 32'(ir0), 32'd1);
    chk("rst_out_valid_k3", 32'(ov3), 32'd0);
    chk("rst_out_valid_k0", 32'(ov0), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid_k3", 32'(ov3), 32'd0);

    // table vectors with exact latency checks
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = tbl[i].a; in_b = tbl[i].b;
      tick();
      in_valid = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
        chk("lat_valid_k3", 32'(ov3), 32'(cyc == 2));
        chk("lat_valid_k0", 32'(ov0), 32'(cyc == 3));
        if (cyc == 2) chk("tbl_sum_k3", 32'(s3), 32'(tbl[i].exp3));
        if (cyc == 3) chk("tbl_sum_k0", 32'(s0), 32'(tbl[i].exp0));
`ifdef APPROX_ADD_ERRSTAT_EN
        if (i == 0 && cyc == 3) begin
          chk("first_err_cnt", ec3, 32'd1);
          chk("first_err_max", 32'(em3), 32'd1);
          chk("exact_err_cnt", ec0, 32'd0);
        end
`endif
        tick();
      end
    end

    // back-to-back stream of 10
    c3 = out_cnt[0]; c0 = out_cnt[1];
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
      chk("b2b_in_ready_k3", 32'(ir3), 32'd1);
      chk("b2b_in_ready_k0", 32'(ir0), 32'd1);
      tick();
    end
    drain(6);
    chk("b2b_count_k3", 32'(out_cnt[0] - c3), 32'd10);
    chk("b2b_count_k0", 32'(out_cnt[1] - c0), 32'd10);

    // stall with full pipeline
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("stall_ov_k3", 32'(ov3), 32'd1);
    chk("stall_ov_k0", 32'(ov0), 32'd1);
    h3 = s3; h0 = s0;
    for (int j = 0; j < 3; j++) begin
      chk("stall_in_ready_k3", 32'(ir3), 32'd0);
      chk("stall_in_ready_k0", 32'(ir0), 32'd0);
      tick();
      chk("stall_hold_k3", 32'(s3), 32'(h3));
      chk("stall_hold_k0", 32'(s0), 32'(h0));
    end
    drain(6);
    chk("stall_drain_k3", 32'(exp_q0.size()), 32'd0);
    chk("stall_drain_k0", 32'(exp_q1.size()), 32'd0);

    // reset with results in flight
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h11;
      tick();
    end
    in_valid = 1'b0;
    chk("inflight_ov_k3", 32'(ov3), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_flush_ov_k3", 32'(ov3), 32'd0);
    chk("rst_flush_ov_k0", 32'(ov0), 32'd0);
`ifdef APPROX_ADD_ERRSTAT_EN
    chk("rst_err_cnt", ec3, 32'd0);
    chk("rst_err_sum", 32'(es3), 32'd0);
`endif
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("rst_no_emit_k3", 32'(ov3), 32'd0);
      chk("rst_no_emit_k0", 32'(ov0), 32'd0);
    end

`ifdef APPROX_ADD_ERRSTAT_EN
    // clear during an erroneous transfer, then saturate the error sum
    in_valid = 1'b1; in_a = 8'h07; in_b = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_err_cnt", ec3, 32'd0);
    chk("clr_err_sum", 32'(es3), 32'd0);
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1; in_a = 8'h7C; in_b = 8'h04;
      tick();
    end
    drain(4);
    chk("sat_err_sum", 32'(es3), 32'h1F);
    chk("sat_err_cnt", ec3, 32'd8);
    chk("sat_err_max", 32'(em3), 32'd4);
`endif

    // randomized traffic against the scoreboard
    for (int j = 0; j < 400; j++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(8);
    chk("final_drain_k3", 32'(exp_q0.size()), 32'd0);
    chk("final_drain_k0", 32'(exp_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
